// File: rtl/rob_pkg.sv
// Shared sizes, tag encoding and entry types for the ROB writeback collector.
package rob_pkg;
  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned PC_W      = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned IDX_W     = $clog2(ROB_DEPTH);
  localparam int unsigned TAG_W     = IDX_W + 1;
  localparam int unsigned PTR_W     = IDX_W + 1;
  localparam int unsigned NUM_CH    = 5;

  // Valid tags keep the MSB clear; all-ones marks an idle channel.
  localparam logic [TAG_W-1:0] TAG_INVALID = '1;

  typedef enum logic [1:0] {
    KIND_ALU    = 2'd0,
    KIND_JUMP   = 2'd1,
    KIND_BRANCH = 2'd2,
    KIND_MEM    = 2'd3
  } kind_e;

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
  } wb_pay_t;

  typedef struct packed {
    logic              valid;
    logic              done;
    kind_e             kind;
    logic [REG_W-1:0]  dest;
    wb_pay_t           pay;
  } rob_entry_t;
endpackage

// File: rtl/rob_wb_decode.sv
// Folds the five writeback channels into one per-entry write enable and payload,
// with fixed priority alu > fwd > jump > branch > mem and same-tag collision detect.
module rob_wb_decode
  import rob_pkg::*;
(
  input  logic [TAG_W-1:0]           alu_target,
  input  logic [DATA_W-1:0]          alu_result,
  input  logic [TAG_W-1:0]           fwd_target,
  input  logic [DATA_W-1:0]          fwd_result,
  input  logic [TAG_W-1:0]           jump_target,
  input  logic [PC_W-1:0]            jump_ori_pc,
  input  logic [PC_W-1:0]            jump_next_pc,
  input  logic [TAG_W-1:0]           br_target,
  input  logic [PC_W-1:0]            br_next_pc,
  input  logic                       br_cmp_res,
  input  logic [TAG_W-1:0]           mem_target,
  input  logic [DATA_W-1:0]          mem_result,
  output logic [ROB_DEPTH-1:0]       wb_en_c,
  output logic [ROB_DEPTH-1:0]       wb_multi_c,
  output wb_pay_t [ROB_DEPTH-1:0]    wb_pay_c
);
  logic [TAG_W-1:0] ch_tag [NUM_CH];
  wb_pay_t          ch_pay [NUM_CH];

  // Channels ordered lowest priority first so later hits override earlier ones.
  always_comb begin
    ch_tag[0] = mem_target;
    ch_pay[0].value = mem_result;
    ch_pay[0].redirect = 1'b0;
    ch_pay[0].redirect_pc = '0;
    ch_tag[1] = br_target;
    ch_pay[1].value = '0;
    ch_pay[1].redirect = br_cmp_res;
    ch_pay[1].redirect_pc = br_next_pc;
    ch_tag[2] = jump_target;
    ch_pay[2].value = DATA_W'(jump_ori_pc + PC_W'(4));
    ch_pay[2].redirect = 1'b1;
    ch_pay[2].redirect_pc = jump_next_pc;
    ch_tag[3] = fwd_target;
    ch_pay[3].value = fwd_result;
    ch_pay[3].redirect = 1'b0;
    ch_pay[3].redirect_pc = '0;
    ch_tag[4] = alu_target;
    ch_pay[4].value = alu_result;
    ch_pay[4].redirect = 1'b0;
    ch_pay[4].redirect_pc = '0;
  end

  always_comb begin
    wb_en_c    = '0;
    wb_multi_c = '0;
    wb_pay_c   = '0;
    for (int i = 0; i < int'(ROB_DEPTH); i++) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (ch_tag[c] == {1'b0, IDX_W'(i)}) begin
          wb_multi_c[i] = wb_multi_c[i] | wb_en_c[i];
          wb_en_c[i]    = 1'b1;
          wb_pay_c[i]   = ch_pay[c];
        end
      end
    end
  end
endmodule

// File: rtl/rob_wb_collect.sv
// ROB completion table: in-order allocate, out-of-order writeback from five
// channels, in-order commit with jump/branch redirect and full-table flush.
module rob_wb_collect
  import rob_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [1:0]        alloc_kind,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic [TAG_W-1:0]  alu_target,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [TAG_W-1:0]  fwd_target,
  input  logic [DATA_W-1:0] fwd_result,
  input  logic [TAG_W-1:0]  mem_target,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [TAG_W-1:0]  jump_target,
  input  logic [PC_W-1:0]   jump_ori_pc,
  input  logic [PC_W-1:0]   jump_next_pc,
  input  logic [TAG_W-1:0]  br_target,
  input  logic [PC_W-1:0]   br_next_pc,
  input  logic              br_cmp_res,
  output logic              commit_valid,
  input  logic              commit_ready,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [REG_W-1:0]  commit_dest,
  output logic [DATA_W-1:0] commit_value,
  output logic              commit_redirect,
  output logic [PC_W-1:0]   commit_pc,
  output logic              flush_out,
  output logic              wb_err
);
  rob_entry_t       entries_q [ROB_DEPTH];
  rob_entry_t       entries_d [ROB_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic             flush_q, flush_d;
  logic             wb_err_q, wb_err_d;

  logic [ROB_DEPTH-1:0]    wb_en_c, wb_multi_c;
  wb_pay_t [ROB_DEPTH-1:0] wb_pay_c;

  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             full_c, alloc_fire_c, commit_fire_c, redirect_fire_c;

  rob_wb_decode u_decode (
    .alu_target   (alu_target),
    .alu_result   (alu_result),
    .fwd_target   (fwd_target),
    .fwd_result   (fwd_result),
    .jump_target  (jump_target),
    .jump_ori_pc  (jump_ori_pc),
    .jump_next_pc (jump_next_pc),
    .br_target    (br_target),
    .br_next_pc   (br_next_pc),
    .br_cmp_res   (br_cmp_res),
    .mem_target   (mem_target),
    .mem_result   (mem_result),
    .wb_en_c      (wb_en_c),
    .wb_multi_c   (wb_multi_c),
    .wb_pay_c     (wb_pay_c)
  );

  assign head_idx        = head_q[IDX_W-1:0];
  assign tail_idx        = tail_q[IDX_W-1:0];
  assign full_c          = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign commit_valid    = entries_q[head_idx].valid && entries_q[head_idx].done;
  assign commit_redirect = commit_valid && entries_q[head_idx].pay.redirect;
  assign commit_tag      = {1'b0, head_idx};
  assign commit_dest     = entries_q[head_idx].dest;
  assign commit_value    = entries_q[head_idx].pay.value;
  assign commit_pc       = entries_q[head_idx].pay.redirect_pc;
  // A pending redirect at head blocks dispatch until the flush lands.
  assign alloc_ready     = !full_c && !commit_redirect;
  assign alloc_tag       = {1'b0, tail_idx};
  assign flush_out       = flush_q;
  assign wb_err          = wb_err_q;

  assign alloc_fire_c    = alloc_valid && alloc_ready;
  assign commit_fire_c   = commit_valid && commit_ready;
  assign redirect_fire_c = commit_fire_c && commit_redirect;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    flush_d   = 1'b0;
    wb_err_d  = wb_err_q;
    if (redirect_fire_c) begin
      entries_d = '{default: '0};
      head_d    = '0;
      tail_d    = '0;
      flush_d   = 1'b1;
    end else begin
      for (int i = 0; i < int'(ROB_DEPTH); i++) begin
        if (wb_en_c[i]) begin
          if (wb_multi_c[i]) wb_err_d = 1'b1;
          if (entries_q[i].valid) begin
            if (entries_q[i].done) begin
              wb_err_d = 1'b1;
            end else begin
              entries_d[i].done = 1'b1;
              entries_d[i].pay  = wb_pay_c[i];
            end
          end
        end
      end
      if (commit_fire_c) begin
        entries_d[head_idx] = '0;
        head_d              = head_q + PTR_W'(1);
      end
      if (alloc_fire_c) begin
        entries_d[tail_idx].valid = 1'b1;
        entries_d[tail_idx].done  = 1'b0;
        entries_d[tail_idx].kind  = kind_e'(alloc_kind);
        entries_d[tail_idx].dest  = alloc_dest;
        entries_d[tail_idx].pay   = '0;
        tail_d                    = tail_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= '{default: '0};
      head_q    <= '0;
      tail_q    <= '0;
      flush_q   <= 1'b0;
      wb_err_q  <= 1'b0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      flush_q   <= flush_d;
      wb_err_q  <= wb_err_d;
    end
  end
endmodule

// File: tb/tb_rob_wb_collect.sv
// Directed bench for rob_wb_collect: ordering, full/wrap, redirects, errors, reset.
module tb_rob_wb_collect;
  import rob_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_valid;
  logic [1:0]        alloc_kind;
  logic [REG_W-1:0]  alloc_dest;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic [TAG_W-1:0]  alu_target, fwd_target, mem_target, jump_target, br_target;
  logic [DATA_W-1:0] alu_result, fwd_result, mem_result;
  logic [PC_W-1:0]   jump_ori_pc, jump_next_pc, br_next_pc;
  logic              br_cmp_res;
  logic              commit_valid, commit_ready;
  logic [TAG_W-1:0]  commit_tag;
  logic [REG_W-1:0]  commit_dest;
  logic [DATA_W-1:0] commit_value;
  logic              commit_redirect;
  logic [PC_W-1:0]   commit_pc;
  logic              flush_out, wb_err;

  int n_assert = 0;
  int n_fail   = 0;

  rob_wb_collect dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_kind(alloc_kind), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alu_target(alu_target), .alu_result(alu_result),
    .fwd_target(fwd_target), .fwd_result(fwd_result),
    .mem_target(mem_target), .mem_result(mem_result),
    .jump_target(jump_target), .jump_ori_pc(jump_ori_pc), .jump_next_pc(jump_next_pc),
    .br_target(br_target), .br_next_pc(br_next_pc), .br_cmp_res(br_cmp_res),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_tag(commit_tag), .commit_dest(commit_dest), .commit_value(commit_value),
    .commit_redirect(commit_redirect), .commit_pc(commit_pc),
    .flush_out(flush_out), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_channels();
    alu_target = TAG_INVALID; fwd_target = TAG_INVALID; mem_target = TAG_INVALID;
    jump_target = TAG_INVALID; br_target = TAG_INVALID;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_alloc(input logic [1:0] k, input logic [REG_W-1:0] d, input logic [TAG_W-1:0] exp_tag);
    check("alloc_tag", 64'(alloc_tag), 64'(exp_tag));
    alloc_valid = 1'b1; alloc_kind = k; alloc_dest = d;
    tick();
    alloc_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alloc_valid = 1'b0; alloc_kind = '0; alloc_dest = '0; commit_ready = 1'b0;
    alu_result = '0; fwd_result = '0; mem_result = '0;
    jump_ori_pc = '0; jump_next_pc = '0; br_next_pc = '0; br_cmp_res = 1'b0;
    idle_channels();
    tick(); tick();
    rst = 1'b0;
    check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    check("rst_commit_valid", 64'(commit_valid), 64'd0);
    check("rst_commit_redirect", 64'(commit_redirect), 64'd0);
    check("rst_flush", 64'(flush_out), 64'd0);
    check("rst_wb_err", 64'(wb_err), 64'd0);

    // In-order commit: tag 1 done first must wait for tag 0.
    do_alloc(KIND_ALU, 5'd1, 5'd0);
    do_alloc(KIND_MEM, 5'd2, 5'd1);
    do_alloc(KIND_ALU, 5'd3, 5'd2);
    mem_target = 5'd1; mem_result = 32'h11; tick(); idle_channels();
    check("order_wait_valid", 64'(commit_valid), 64'd0);
    alu_target = 5'd0; alu_result = 32'hA0; tick(); idle_channels();
    check("order_c0_valid", 64'(commit_valid), 64'd1);
    check("order_c0_tag", 64'(commit_tag), 64'd0);
    check("order_c0_value", 64'(commit_value), 64'hA0);
    check("order_c0_dest", 64'(commit_dest), 64'd1);
    commit_ready = 1'b1; tick();
    check("order_c1_valid", 64'(commit_valid), 64'd1);
    check("order_c1_tag", 64'(commit_tag), 64'd1);
    check("order_c1_value", 64'(commit_value), 64'h11);
    check("order_c1_dest", 64'(commit_dest), 64'd2);
    tick(); commit_ready = 1'b0;
    check("order_c2_notdone", 64'(commit_valid), 64'd0);

    // Fill, then commit+alloc together while full, then wrap.
    do_reset();
    for (int i = 0; i < 16; i++) do_alloc(KIND_ALU, REG_W'(i + 1), TAG_W'(i));
    check("full_alloc_ready", 64'(alloc_ready), 64'd0);
    alu_target = 5'd0; alu_result = 32'h5; tick(); idle_channels();
    check("full_commit_valid", 64'(commit_valid), 64'd1);
    alloc_valid = 1'b1; alloc_kind = KIND_ALU; alloc_dest = 5'd9; commit_ready = 1'b1;
    check("full_pre_edge_ready", 64'(alloc_ready), 64'd0);
    tick(); commit_ready = 1'b0;
    check("freed_alloc_ready", 64'(alloc_ready), 64'd1);
    check("wrap_alloc_tag", 64'(alloc_tag), 64'd0);
    tick(); alloc_valid = 1'b0;
    check("refull_alloc_ready", 64'(alloc_ready), 64'd0);
    check("refull_alloc_tag", 64'(alloc_tag), 64'd1);

    // Jump redirect and flush; a writeback in the flush cycle is dropped.
    do_reset();
    do_alloc(KIND_JUMP, 5'd5, 5'd0);
    do_alloc(KIND_ALU, 5'd6, 5'd1);
    jump_target = 5'd0; jump_ori_pc = 32'h100; jump_next_pc = 32'h200; tick(); idle_channels();
    check("jump_valid", 64'(commit_valid), 64'd1);
    check("jump_value", 64'(commit_value), 64'h104);
    check("jump_redirect", 64'(commit_redirect), 64'd1);
    check("jump_pc", 64'(commit_pc), 64'h200);
    check("jump_block_alloc", 64'(alloc_ready), 64'd0);
    commit_ready = 1'b1; alu_target = 5'd1; alu_result = 32'hDEAD; tick();
    commit_ready = 1'b0; idle_channels();
    check("jump_flush", 64'(flush_out), 64'd1);
    check("jump_empty", 64'(commit_valid), 64'd0);
    check("jump_tail0", 64'(alloc_tag), 64'd0);
    check("jump_no_err", 64'(wb_err), 64'd0);
    tick();
    check("jump_flush_pulse", 64'(flush_out), 64'd0);

    // Branch not taken then taken.
    do_alloc(KIND_BRANCH, 5'd0, 5'd0);
    do_alloc(KIND_BRANCH, 5'd0, 5'd1);
    br_target = 5'd0; br_cmp_res = 1'b0; br_next_pc = 32'h80; tick(); idle_channels();
    check("br_nt_valid", 64'(commit_valid), 64'd1);
    check("br_nt_redirect", 64'(commit_redirect), 64'd0);
    commit_ready = 1'b1; tick(); commit_ready = 1'b0;
    check("br_nt_flush", 64'(flush_out), 64'd0);
    br_target = 5'd1; br_cmp_res = 1'b1; br_next_pc = 32'h40; tick(); idle_channels();
    check("br_t_tag", 64'(commit_tag), 64'd1);
    check("br_t_redirect", 64'(commit_redirect), 64'd1);
    check("br_t_pc", 64'(commit_pc), 64'h40);
    commit_ready = 1'b1; tick(); commit_ready = 1'b0;
    check("br_t_flush", 64'(flush_out), 64'd1);
    check("br_t_empty", 64'(commit_valid), 64'd0);

    // Writeback to an already-done entry.
    do_alloc(KIND_ALU, 5'd3, 5'd0);
    alu_target = 5'd0; alu_result = 32'h77; tick(); idle_channels();
    check("dup_pre_err", 64'(wb_err), 64'd0);
    fwd_target = 5'd0; fwd_result = 32'h99; tick(); idle_channels();
    check("dup_err", 64'(wb_err), 64'd1);
    check("dup_value_kept", 64'(commit_value), 64'h77);
    do_reset();
    check("dup_rst_err", 64'(wb_err), 64'd0);

    // Non-valid target ignored, parallel channels, then alu/mem collision.
    for (int i = 0; i < 4; i++) do_alloc(KIND_ALU, REG_W'(i), TAG_W'(i));
    alu_target = 5'd7; alu_result = 32'h1; tick(); idle_channels();
    check("nonvalid_no_err", 64'(wb_err), 64'd0);
    fwd_target = 5'd0; fwd_result = 32'h10; mem_target = 5'd1; mem_result = 32'h11;
    alu_target = 5'd2; alu_result = 32'h12; tick(); idle_channels();
    check("parallel_no_err", 64'(wb_err), 64'd0);
    alu_target = 5'd3; alu_result = 32'hAAAA; mem_target = 5'd3; mem_result = 32'hBBBB;
    tick(); idle_channels();
    check("coll_err", 64'(wb_err), 64'd1);
    check("coll_c0_value", 64'(commit_value), 64'h10);
    commit_ready = 1'b1; tick();
    check("coll_c1_value", 64'(commit_value), 64'h11);
    tick();
    check("coll_c2_value", 64'(commit_value), 64'h12);
    tick();
    check("coll_c3_tag", 64'(commit_tag), 64'd3);
    check("coll_c3_alu_wins", 64'(commit_value), 64'hAAAA);
    tick(); commit_ready = 1'b0;
    check("coll_drained", 64'(commit_valid), 64'd0);
    check("coll_err_sticky", 64'(wb_err), 64'd1);

    // Reset with entries pending.
    for (int i = 4; i < 9; i++) do_alloc(KIND_MEM, REG_W'(i), TAG_W'(i));
    mem_target = 5'd4; mem_result = 32'h44; tick(); idle_channels();
    check("pend_valid", 64'(commit_valid), 64'd1);
    do_reset();
    check("mid_rst_commit_valid", 64'(commit_valid), 64'd0);
    check("mid_rst_alloc_tag", 64'(alloc_tag), 64'd0);
    check("mid_rst_wb_err", 64'(wb_err), 64'd0);
    check("mid_rst_alloc_ready", 64'(alloc_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
